mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Two-requester arbiter that shares one 128-bit line-granular memory/L2 port between the instruction cache (read-only) and the data cache (read and write-back).
- Sits between the Icache/Dcache memory interfaces and the single memory port.
- Registers the winning request onto the memory side and routes the memory response back to the granted cache.
- Uses round-robin on contention and enforces a one-cycle cooldown after each completion. The cooldown absorbs caches that drop their request one cycle after mem_ready.

Parameters:
ADDR_W, 30, word-address width (line address in upper bits, word index in [1:0])
DATA_W, 128, line width in bits

Ports:
clk  input  1  single clock, rising edge
proc_reset  input  1  asynchronous, active-high reset
i_read  input  1  Icache line-read request, held until i_ready
i_addr  input  ADDR_W  Icache request address
i_rdata  output  DATA_W  line data to Icache (copy of mem_rdata)
i_ready  output  1  one-cycle completion pulse to Icache
d_read  input  1  Dcache line-read request, held until d_ready
d_write  input  1  Dcache write-back request, held until d_ready
d_addr  input  ADDR_W  Dcache request address
d_wdata  input  DATA_W  Dcache write-back line
d_rdata  output  DATA_W  line data to Dcache (copy of mem_rdata)
d_ready  output  1  one-cycle completion pulse to Dcache
mem_read  output  1  memory read strobe, registered
mem_write  output  1  memory write strobe, registered
mem_addr  output  ADDR_W  memory address, registered
mem_wdata  output  DATA_W  memory write data, registered
mem_rdata  input  DATA_W  memory read data
mem_ready  input  1  memory completion pulse
grant  output  2  debug: 2'b01 = I in service, 2'b10 = D in service, 2'b00 = none

Behaviour:
- Reset (async, proc_reset=1):
  - state=IDLE; last_served=D, so I wins the first tie; mask=none.
  - mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0, grant=0, i_ready=0, d_ready=0.
  - A reset mid-transaction abandons it. No ready is issued for it.
- States: IDLE, SERVE_I, SERVE_D, COOL.
- Request eligibility:
  - I is eligible when i_read=1.
  - D is eligible when d_read|d_write=1.
  - In COOL, the requester served last is masked (ineligible).
- Arbitration, evaluated in IDLE and COOL:
  - Only one eligible requester: grant it.
  - Both eligible: grant the one that is not last_served.
  - Next edge: state goes to SERVE_x; mem_* outputs are loaded from that requester; grant is set.
- I grant loads: mem_read=1, mem_write=0, mem_addr=i_addr, mem_wdata=0.
- D grant loads: mem_addr=d_addr, mem_wdata=d_wdata.
  - mem_write=d_write.
  - mem_read=d_read & ~d_write. If both are set, write wins; this is a protocol violation and a single write is issued.
- Latency: request seen in cycle n → memory strobe visible in cycle n+1.
- mem_* outputs hold constant throughout SERVE_x, independent of later requester input changes.
- In SERVE_x with mem_ready=1:
  - x_ready=1 combinationally in that cycle; the other ready stays 0.
  - Next edge: mem_read=0, mem_write=0, grant=0, last_served=x, mask=x, state=COOL.
  - mem_addr and mem_wdata keep their values.
- In SERVE_x with mem_ready=0: remain in SERVE_x.
- COOL lasts exactly one cycle. It arbitrates with the mask applied. If nothing is eligible, next state is IDLE with mask cleared.
- Back-to-back service: one requester can be served every (memory latency + 2) cycles.
  - The other requester can be granted from COOL, with no IDLE bubble.
  - The same requester re-requesting always passes through COOL, then IDLE, then SERVE.
- Stray mem_ready in IDLE or COOL is ignored: no ready pulse and no state change.
- i_rdata and d_rdata equal mem_rdata at all times. Only the ready pulses are qualified.
- At most one of i_ready/d_ready is high in any cycle. mem_read and mem_write are never high together.

Test Plan:
- I-only read:
  - Stimulus: i_read=1, i_addr=30'h100 at cycle 0; memory asserts mem_ready in cycle 3 with mem_rdata=128'hA5…A5.
  - Expect: mem_read=1, mem_addr=30'h100 in cycles 1–3; i_ready=1 and i_rdata=A5…A5 only in cycle 3; mem_read=0 and state=COOL in cycle 4; i_read dropped in cycle 4 is not re-granted.
- Simultaneous first requests:
  - Stimulus: i_read and d_read both asserted at cycle 0 after reset.
  - Expect: I granted first (grant=01); D granted from COOL the cycle after i_ready (grant=10), with no IDLE in between.
- Round-robin fairness:
  - Stimulus: both requesters continuously re-requesting; memory latency 2.
  - Expect: grants alternate I, D, I, D over 8 transactions; no requester served twice in a row.
- Dcache write-back then read:
  - Stimulus: d_write=1, d_addr=30'h2C0, d_wdata=128'h1234… until d_ready; then d_read=1, d_addr=30'h040.
  - Expect: one mem_write with matching addr/data; then COOL, IDLE; then mem_read at 30'h040.
- Protocol edges:
  - Stimulus: d_read=d_write=1 together.
  - Expect: mem_write=1, mem_read=0.
  - Stimulus: mem_ready pulse while IDLE.
  - Expect: no i_ready or d_ready.
- Reset mid-transaction:
  - Stimulus: proc_reset asserted asynchronously (between edges) during SERVE_D.
  - Expect: mem_read, mem_write and grant drop to 0 immediately; no d_ready; after release, the next simultaneous request grants I first.

Source files
------------

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester round-robin arbiter sharing one line-granular memory port
module mem_arbiter #(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              proc_reset,
  // Icache side (read-only)
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ready,
  // Dcache side (read and write-back)
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  // memory side
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  // debug
  output logic [1:0]        grant
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SERVE_I = 2'd1;
  localparam logic [1:0] ST_SERVE_D = 2'd2;
  localparam logic [1:0] ST_COOL    = 2'd3;

  // mask bit 0 blocks I, bit 1 blocks D; it only takes effect in COOL
  logic [1:0]        state_q, state_d;
  logic              last_d_q, last_d_d;
  logic [1:0]        mask_q, mask_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [1:0]        grant_q, grant_d;

  logic in_cool;
  logic i_elig;
  logic d_elig;
  logic pick_i;
  logic pick_d;

  // eligibility and round-robin choice; on a tie the side not served last wins
  always_comb begin
    in_cool = (state_q == ST_COOL);
    i_elig  = i_read & ~(in_cool & mask_q[0]);
    d_elig  = (d_read | d_write) & ~(in_cool & mask_q[1]);
    pick_i  = i_elig & (~d_elig | last_d_q);
    pick_d  = d_elig & (~i_elig | ~last_d_q);
  end

  // next-state and registered memory command
  always_comb begin
    state_d     = state_q;
    last_d_d    = last_d_q;
    mask_d      = mask_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    grant_d     = grant_q;
    case (state_q)
      ST_IDLE, ST_COOL: begin
        if (pick_i) begin
          state_d     = ST_SERVE_I;
          mem_read_d  = 1'b1;
          mem_write_d = 1'b0;
          mem_addr_d  = i_addr;
          mem_wdata_d = '0;
          grant_d     = 2'b01;
        end else if (pick_d) begin
          // a read+write collision from the Dcache issues only the write
          state_d     = ST_SERVE_D;
          mem_read_d  = d_read & ~d_write;
          mem_write_d = d_write;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          grant_d     = 2'b10;
        end else begin
          state_d = ST_IDLE;
          mask_d  = 2'b00;
        end
      end
      ST_SERVE_I: begin
        if (mem_ready) begin
          state_d     = ST_COOL;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          grant_d     = 2'b00;
          last_d_d    = 1'b0;
          mask_d      = 2'b01;
        end
      end
      ST_SERVE_D: begin
        if (mem_ready) begin
          state_d     = ST_COOL;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          grant_d     = 2'b00;
          last_d_d    = 1'b1;
          mask_d      = 2'b10;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // state registers; reset abandons any transaction in flight
  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      state_q     <= ST_IDLE;
      last_d_q    <= 1'b1;
      mask_q      <= 2'b00;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      grant_q     <= 2'b00;
    end else begin
      state_q     <= state_d;
      last_d_q    <= last_d_d;
      mask_q      <= mask_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      grant_q     <= grant_d;
    end
  end

  // completion pulses are qualified by the service state; data is passed straight through
  always_comb begin
    i_ready   = (state_q == ST_SERVE_I) & mem_ready;
    d_ready   = (state_q == ST_SERVE_D) & mem_ready;
    i_rdata   = mem_rdata;
    d_rdata   = mem_rdata;
    mem_read  = mem_read_q;
    mem_write = mem_write_q;
    mem_addr  = mem_addr_q;
    mem_wdata = mem_wdata_q;
    grant     = grant_q;
  end

endmodule
